// File: rtl/rtc_bus_timing_if.sv
// rtl/rtc_bus_timing_if.sv - signal bundle between the RTC bus timing generator and its neighbours
//
// Purpose: groups the run/direction controls and the phase, counter, bus-direction,
//          pin-strobe and status outputs of rtc_bus_timing.
// Signals:
//   enable     1  run transactions back-to-back (driven by the slave side)
//   escritura  1  1 = current step is a write, 0 = read (driven by the slave side)
//   state      3  phase code
//   tiempos    5  intra-phase clock counter
//   flag_z     1  1 = FPGA data-bus drivers high-Z
//   cs_n       1  RTC chip select, active low
//   as         1  RTC address strobe / ALE, active high
//   rd_n       1  RTC read strobe, active low
//   wr_n       1  RTC write strobe, active low
//   busy       1  transaction in progress
//   done       1  one-clock pulse at the end of a transaction
// Modports: master = timing generator, slave = controller / environment.
interface rtc_bus_timing_if;
    logic       enable;
    logic       escritura;
    logic [2:0] state;
    logic [4:0] tiempos;
    logic       flag_z;
    logic       cs_n;
    logic       as;
    logic       rd_n;
    logic       wr_n;
    logic       busy;
    logic       done;

    modport master (
        input  enable, escritura,
        output state, tiempos, flag_z, cs_n, as, rd_n, wr_n, busy, done
    );

    modport slave (
        output enable, escritura,
        input  state, tiempos, flag_z, cs_n, as, rd_n, wr_n, busy, done
    );
endinterface

// File: rtl/rtc_bus_timing.sv
// rtl/rtc_bus_timing.sv - bus-cycle timing generator for the multiplexed A/D RTC interface
//
// Purpose: sequences the RTC bus phases (idle, address, read or write, release),
//          producing the phase code, intra-phase counter, bus direction, RTC pin
//          strobes and busy/done status. All outputs are registered and aligned.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   bus        master modport of rtc_bus_timing_if (enable/escritura in; state,
//              tiempos, flag_z, cs_n, as, rd_n, wr_n, busy, done out)
//   trans_cnt  out  [15:0] completed-transaction count, present only when
//              RTC_TRANS_COUNT_EN is defined
// Parameters:
//   PHASE_LEN  clocks per bus phase (28..32)
//   IDLE_LEN   clocks spent in alta_imp between transactions (>=1)
module rtc_bus_timing #(
    parameter int PHASE_LEN = 32,
    parameter int IDLE_LEN  = 32
) (
    input  logic             clk,
    input  logic             reset,
    rtc_bus_timing_if.master bus
`ifdef RTC_TRANS_COUNT_EN
    ,
    output logic [15:0]      trans_cnt
`endif
);

    typedef enum logic [2:0] {
        TRAN_Z_E       = 3'b000,
        ALTA_IMP       = 3'b001,
        ENVIO_DIR      = 3'b010,
        TRAN_E_Z       = 3'b011,
        LEER           = 3'b100,
        ESCRIBIR       = 3'b101,
        ALTA_IMP_FINAL = 3'b111
    } phase_t;

    localparam logic [4:0]  T_LAST    = 5'(PHASE_LEN - 1);
    localparam logic [4:0]  T_WIN_LO  = 5'd2;
    localparam logic [4:0]  T_WIN_HI  = 5'(PHASE_LEN - 3);
    localparam logic [15:0] IDLE_LAST = 16'(IDLE_LEN - 1);

    phase_t      phase;
    phase_t      phase_nx;
    logic [4:0]  tiempos_q;
    logic [4:0]  tiempos_nx;
    logic [15:0] idle_cnt;
    logic [15:0] idle_cnt_nx;
    logic        win_nx;

    logic        flag_z_q;
    logic        cs_n_q;
    logic        as_q;
    logic        rd_n_q;
    logic        wr_n_q;
    logic        busy_q;
    logic        done_q;

    // Next phase / counter. In alta_imp the idle counter only advances while
    // enable is high and is held at zero otherwise, so a re-enable from the
    // parked state always waits the full IDLE_LEN before tran_Z_E.
    always_comb begin
        phase_nx    = phase;
        tiempos_nx  = tiempos_q + 5'd1;
        idle_cnt_nx = idle_cnt;
        if (phase == ALTA_IMP) begin
            tiempos_nx = '0;
            if (!bus.enable) begin
                idle_cnt_nx = '0;
            end else if (idle_cnt == IDLE_LAST) begin
                idle_cnt_nx = '0;
                phase_nx    = TRAN_Z_E;
            end else begin
                idle_cnt_nx = idle_cnt + 16'd1;
            end
        end else if (tiempos_q == T_LAST) begin
            tiempos_nx = '0;
            case (phase)
                TRAN_Z_E:       phase_nx = ENVIO_DIR;
                // escritura is looked at only here, on the last clock of envio_dir
                ENVIO_DIR:      phase_nx = bus.escritura ? ESCRIBIR : TRAN_E_Z;
                TRAN_E_Z:       phase_nx = LEER;
                LEER, ESCRIBIR: phase_nx = ALTA_IMP_FINAL;
                default:        phase_nx = ALTA_IMP;
            endcase
        end
    end

    // Strobe window is decoded from the next phase/counter so the registered
    // strobes line up with the registered state and tiempos.
    assign win_nx = (tiempos_nx >= T_WIN_LO) && (tiempos_nx <= T_WIN_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase     <= ALTA_IMP;
            tiempos_q <= '0;
            idle_cnt  <= '0;
            flag_z_q  <= 1'b1;
            cs_n_q    <= 1'b1;
            as_q      <= 1'b0;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            phase     <= phase_nx;
            tiempos_q <= tiempos_nx;
            idle_cnt  <= idle_cnt_nx;
            flag_z_q  <= !(phase_nx inside {TRAN_Z_E, ENVIO_DIR, ESCRIBIR});
            as_q      <= (phase_nx == ENVIO_DIR) && win_nx;
            wr_n_q    <= !((phase_nx == ESCRIBIR) && win_nx);
            rd_n_q    <= !((phase_nx == LEER) && win_nx);
            cs_n_q    <= !(((phase_nx == ESCRIBIR) || (phase_nx == LEER)) && win_nx);
            busy_q    <= (phase_nx != ALTA_IMP);
            done_q    <= (phase_nx == ALTA_IMP_FINAL) && (tiempos_nx == T_LAST);
        end
    end

`ifdef RTC_TRANS_COUNT_EN
    // Counts on the clock after each done pulse; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trans_cnt <= '0;
        end else if (done_q) begin
            trans_cnt <= trans_cnt + 16'd1;
        end
    end
`endif

    assign bus.state   = phase;
    assign bus.tiempos = tiempos_q;
    assign bus.flag_z  = flag_z_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.as      = as_q;
    assign bus.rd_n    = rd_n_q;
    assign bus.wr_n    = wr_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
